// File: rtl/core_sequencer.sv
// Multi-cycle fetch/decode/execute sequencer. It handshakes with the instruction and data memories,
// gates the IR, PC and register-file writes, and keeps sticky fault flags plus a retired-instruction count.
module core_sequencer #(
    parameter int MEM_TIMEOUT = 255,
    parameter int TO_W        = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        run,
    input  logic [6:0]  opcode,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic        reg_write_dec,
    input  logic        imem_ready,
    input  logic        dmem_ready,
    output logic        imem_req,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic        ir_we,
    output logic        pc_we,
    output logic        reg_write,
    output logic        retired,
    output logic [31:0] instr_count,
    output logic [2:0]  state_out,
    output logic        bus_error,
    output logic        illegal_instr
);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_FETCH     = 3'd1;
    localparam logic [2:0] S_DECODE    = 3'd2;
    localparam logic [2:0] S_EXECUTE   = 3'd3;
    localparam logic [2:0] S_MEMORY    = 3'd4;
    localparam logic [2:0] S_WRITEBACK = 3'd5;
    localparam logic [2:0] S_ERROR     = 3'd6;

    localparam logic [TO_W-1:0] TO_LAST = TO_W'(MEM_TIMEOUT - 1);

    logic [2:0]      r_state;
    logic [2:0]      w_state_next;
    logic [TO_W-1:0] r_wait_cnt;
    logic [31:0]     r_instr_count;
    logic            r_bus_error;
    logic            r_illegal_instr;
    logic            w_opcode_legal;
    logic            w_wait_cycle;
    logic            w_wait_expired;
    logic            w_after_retire;

    always_comb begin
        w_opcode_legal = 1'b0;
        case (opcode)
            7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
            7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111: w_opcode_legal = 1'b1;
            default: w_opcode_legal = 1'b0;
        endcase
    end

    // A request cycle that did not get its ready; the last permitted one times out.
    assign w_wait_cycle   = ((r_state == S_FETCH) && !imem_ready) ||
                            ((r_state == S_MEMORY) && !dmem_ready);
    assign w_wait_expired = (MEM_TIMEOUT != 0) && (r_wait_cnt == TO_LAST);
    assign w_after_retire = run;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:      if (run) w_state_next = S_FETCH;
            S_FETCH: begin
                if (imem_ready)          w_state_next = S_DECODE;
                else if (w_wait_expired) w_state_next = S_ERROR;
            end
            S_DECODE:    w_state_next = w_opcode_legal ? S_EXECUTE : S_ERROR;
            S_EXECUTE: begin
                if (mem_read || mem_write) w_state_next = S_MEMORY;
                else if (reg_write_dec)    w_state_next = S_WRITEBACK;
                else                       w_state_next = w_after_retire ? S_FETCH : S_IDLE;
            end
            S_MEMORY: begin
                if (dmem_ready) begin
                    if (mem_read) w_state_next = S_WRITEBACK;
                    else          w_state_next = w_after_retire ? S_FETCH : S_IDLE;
                end else if (w_wait_expired) begin
                    w_state_next = S_ERROR;
                end
            end
            S_WRITEBACK: w_state_next = w_after_retire ? S_FETCH : S_IDLE;
            S_ERROR:     w_state_next = S_ERROR;
            default:     w_state_next = S_ERROR;
        endcase
    end

    always_comb begin
        imem_req  = 1'b0;
        ir_we     = 1'b0;
        dmem_req  = 1'b0;
        dmem_we   = 1'b0;
        pc_we     = 1'b0;
        reg_write = 1'b0;
        retired   = 1'b0;
        case (r_state)
            S_FETCH: begin
                imem_req = 1'b1;
                ir_we    = imem_ready;
            end
            S_EXECUTE: begin
                if (!mem_read && !mem_write && !reg_write_dec) begin
                    pc_we   = 1'b1;
                    retired = 1'b1;
                end
            end
            S_MEMORY: begin
                dmem_req = 1'b1;
                dmem_we  = mem_write;
                if (dmem_ready && !mem_read) begin
                    pc_we   = 1'b1;
                    retired = 1'b1;
                end
            end
            S_WRITEBACK: begin
                reg_write = 1'b1;
                pc_we     = 1'b1;
                retired   = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wait_cnt      <= '0;
            r_instr_count   <= '0;
            r_bus_error     <= 1'b0;
            r_illegal_instr <= 1'b0;
        end else begin
            if ((w_state_next != r_state) &&
                ((w_state_next == S_FETCH) || (w_state_next == S_MEMORY))) begin
                r_wait_cnt <= '0;
            end else if (w_wait_cycle) begin
                r_wait_cnt <= r_wait_cnt + 1'b1;
            end
            if (w_wait_cycle && w_wait_expired) r_bus_error <= 1'b1;
            if ((r_state == S_DECODE) && !w_opcode_legal) r_illegal_instr <= 1'b1;
            if (retired) r_instr_count <= r_instr_count + 32'd1;
        end
    end

    assign instr_count   = r_instr_count;
    assign state_out     = r_state;
    assign bus_error     = r_bus_error;
    assign illegal_instr = r_illegal_instr;

endmodule
